// File: rtl/rect_compositor.sv
// rtl/rect_compositor.sv - three-layer rectangle colour compositor with per-frame bound latching
// Two strobe-qualified stages: hit test on shadow bounds, then priority colour select with sync delay.
module rect_compositor #(
  parameter logic [11:0] BG_COLOR = 12'h000,
  parameter logic [11:0] COLOR_A  = 12'hF00,
  parameter logic [11:0] COLOR_B  = 12'h0F0,
  parameter logic [11:0] COLOR_C  = 12'h00F
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  input  logic [9:0]  i_x,
  input  logic [8:0]  i_y,
  input  logic        i_active,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_animate,
  input  logic [11:0] i_a_x1,
  input  logic [11:0] i_a_x2,
  input  logic [11:0] i_a_y1,
  input  logic [11:0] i_a_y2,
  input  logic [11:0] i_b_x1,
  input  logic [11:0] i_b_x2,
  input  logic [11:0] i_b_y1,
  input  logic [11:0] i_b_y2,
  input  logic [11:0] i_c_x1,
  input  logic [11:0] i_c_x2,
  input  logic [11:0] i_c_y1,
  input  logic [11:0] i_c_y2,
  output logic [3:0]  o_r,
  output logic [3:0]  o_g,
  output logic [3:0]  o_b,
  output logic        o_hs,
  output logic        o_vs
);

  localparam int NB = 12;

  // Bound slots per rectangle in order x1, x2, y1, y2; A at 0, B at 4, C at 8.
  logic [11:0] bnd_in [NB];
  logic [11:0] bnd_q  [NB];
  logic [11:0] bnd_d  [NB];

  logic [11:0] x_ext, y_ext;
  logic [2:0]  hit_c;
  logic [2:0]  hit_q, hit_d;
  logic        act_q, act_d;
  logic        hs1_q, hs1_d;
  logic        vs1_q, vs1_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;

  assign x_ext = {2'b00, i_x};
  assign y_ext = {3'b000, i_y};

  always_comb begin
    bnd_in[0]  = i_a_x1;
    bnd_in[1]  = i_a_x2;
    bnd_in[2]  = i_a_y1;
    bnd_in[3]  = i_a_y2;
    bnd_in[4]  = i_b_x1;
    bnd_in[5]  = i_b_x2;
    bnd_in[6]  = i_b_y1;
    bnd_in[7]  = i_b_y2;
    bnd_in[8]  = i_c_x1;
    bnd_in[9]  = i_c_x2;
    bnd_in[10] = i_c_y1;
    bnd_in[11] = i_c_y2;
  end

  // Strict inequalities make degenerate and one-wide boxes empty for free.
  function automatic logic in_box(input logic [11:0] x, input logic [11:0] y,
                                  input logic [11:0] x1, input logic [11:0] x2,
                                  input logic [11:0] y1, input logic [11:0] y2);
    return (x > x1) && (x < x2) && (y > y1) && (y < y2);
  endfunction

  always_comb begin
    hit_c[0] = in_box(x_ext, y_ext, bnd_q[0], bnd_q[1], bnd_q[2],  bnd_q[3]);
    hit_c[1] = in_box(x_ext, y_ext, bnd_q[4], bnd_q[5], bnd_q[6],  bnd_q[7]);
    hit_c[2] = in_box(x_ext, y_ext, bnd_q[8], bnd_q[9], bnd_q[10], bnd_q[11]);
  end

  always_comb begin
    bnd_d = bnd_q;
    hit_d = hit_q;
    act_d = act_q;
    hs1_d = hs1_q;
    vs1_d = vs1_q;
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (i_pix_stb) begin
      // The hit test above still sees the old bounds on a load edge.
      if (i_animate) begin
        bnd_d = bnd_in;
      end
      hit_d = hit_c;
      act_d = i_active;
      hs1_d = i_hs;
      vs1_d = i_vs;
      if (!act_q) begin
        rgb_d = 12'h000;
      end else if (hit_q[0]) begin
        rgb_d = COLOR_A;
      end else if (hit_q[1]) begin
        rgb_d = COLOR_B;
      end else if (hit_q[2]) begin
        rgb_d = COLOR_C;
      end else begin
        rgb_d = BG_COLOR;
      end
      hs_d = hs1_q;
      vs_d = vs1_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      bnd_q <= '{default: 12'h000};
      hit_q <= 3'b000;
      act_q <= 1'b0;
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
      rgb_q <= 12'h000;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      bnd_q <= bnd_d;
      hit_q <= hit_d;
      act_q <= act_d;
      hs1_q <= hs1_d;
      vs1_q <= vs1_d;
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign o_r  = rgb_q[11:8];
  assign o_g  = rgb_q[7:4];
  assign o_b  = rgb_q[3:0];
  assign o_hs = hs_q;
  assign o_vs = vs_q;

endmodule

// File: doc/rect_compositor.md
# rect_compositor

Pixel-colour back end for the 640x480 display path. Sits downstream of the VGA timing generator and the three square animators: takes the current pixel position, sync and active flags, plus three rectangle bounding boxes. Produces registered 4-bit-per-channel RGB with fixed layer priority, and sync outputs delayed to match. Rectangle bounds are shadow-latched once per frame so a moving square never tears mid-frame.

## Interface

Parameters:
- BG_COLOR, 12'h000, background {R,G,B} when no rectangle hits
- COLOR_A, 12'hF00, colour of rectangle A (top layer)
- COLOR_B, 12'h0F0, colour of rectangle B (middle layer)
- COLOR_C, 12'h00F, colour of rectangle C (bottom layer)

Ports:
- i_clk  in  1  system clock (100 MHz)
- i_rst  in  1  synchronous, active-low reset
- i_pix_stb  in  1  pixel strobe; 1-cycle pulse per pixel (25 MHz rate)
- i_x  in  10  current pixel x from timing generator
- i_y  in  9  current pixel y from timing generator
- i_active  in  1  1 = pixel inside 640x480 visible area
- i_hs  in  1  horizontal sync from timing generator (active-low)
- i_vs  in  1  vertical sync from timing generator (active-low)
- i_animate  in  1  end-of-visible-frame pulse, one strobe wide
- i_a_x1, i_a_x2, i_a_y1, i_a_y2  in  12 each  rectangle A bounds
- i_b_x1, i_b_x2, i_b_y1, i_b_y2  in  12 each  rectangle B bounds
- i_c_x1, i_c_x2, i_c_y1, i_c_y2  in  12 each  rectangle C bounds
- o_r, o_g, o_b  out  4 each  registered colour outputs
- o_hs, o_vs  out  1 each  sync outputs, delayed to align with colour

## Operation

- Sampling and state changes occur only on i_clk edges where i_pix_stb=1. Exception: reset, which acts on every edge.
- Shadow bounds: 12 x 12-bit registers.
  - On a strobe edge with i_animate=1, all 12 load from the i_* bound inputs in the same edge.
  - At all other times they hold. Input bound changes mid-frame have no visible effect.
- Hit test, stage 1:
  - i_x and i_y are zero-extended to 12 bits.
  - hit_A = (x > ax1) & (x < ax2) & (y > ay1) & (y < ay2), using strict inequalities and unsigned compare. Same form for B and C.
  - Registered: hit_A/B/C, i_active, i_hs, i_vs.
- Colour select, stage 2:
  - Priority A > B > C > BG_COLOR.
  - If the stage-1 active flag = 0, colour is forced to 12'h000 regardless of hits.
  - Registered to {o_r,o_g,o_b}. Stage-1 hs/vs are registered to o_hs/o_vs.
- Degenerate box (x1 >= x2 or y1 >= y2, including x1+1 == x2) never hits.
- Bounds beyond 639/479 are legal; the compare is unaffected and the active flag blanks the off-screen area.

## Timing

- Latency: exactly 2 pixel strobes from i_x/i_y/i_active/i_hs/i_vs to the corresponding o_* values. Sync and colour stay aligned at all times.
- Outputs change only on the i_clk edge of a strobe and hold for the 3 clocks between strobes.
- Shadow-load edge vs hit test: the hit test on the same strobe edge as an i_animate load uses the OLD bounds. New bounds first apply to the pixel sampled on the next strobe.
- Reset (i_rst=0 on any edge, overriding i_pix_stb):
  - shadow bounds = 0, so every rectangle is empty
  - hit flags = 0, stage-1 active = 0
  - stage-1 hs/vs = 1, o_hs = o_vs = 1 (sync idle)
  - o_r = o_g = o_b = 0
- Reset released mid-frame: the first two strobes output black with sync idle. Rectangles stay invisible until the first i_animate load.
- i_animate with i_pix_stb=0: ignored.

## Test plan

- Reset: hold i_rst=0 for 8 clocks with strobes toggling -> o_rgb=12'h000, o_hs=o_vs=1 throughout. After release with i_active=1, output is BG_COLOR only and no rectangle appears before the first i_animate.
- Latency/alignment: load A=(100,200,50,150), drive x=101,y=51,active=1,hs=0 at strobe n -> o_rgb=12'hF00 and o_hs=0 exactly at strobe n+2. x=100 at the same y -> BG_COLOR (strict edge).
- Priority: A=(0,300,0,300), B=(100,400,100,400), C=(200,500,200,500). Pixel (250,250) -> 12'hF00; (350,350) -> 12'h0F0; (450,450) -> 12'h00F; (600,100) -> 12'h000.
- Shadow hold: after a load, change i_a_* to (0,639,0,479) mid-frame -> output unchanged until the next strobe with i_animate=1. A same-edge pixel uses the old bounds; the next pixel uses the new ones.
- Blanking/degenerate: pixel inside A with i_active=0 -> 12'h000. A=(300,301,10,20) or A=(300,300,10,20) -> A never visible.
- Mid-frame reset: assert i_rst=0 for one clock during a rectangle hit -> next edge o_rgb=0, o_hs=o_vs=1, shadow cleared. Rectangles return only after the next i_animate.
